// File: rtl/ifm_window_reader_if.sv
// Read-side port bundle between the IFM window reader and the ping-pong IFM memory array.
// The reader drives everything except frame_ready and next_stall.
interface ifm_window_reader_if #(
   parameter int ADDRESS_SIZE_IFM = 10
);
   logic                        frame_ready;
   logic                        next_stall;
   logic                        frame_ack;
   logic                        ifm_sel;
   logic                        ifm_enable_read_A_next;
   logic                        ifm_enable_read_B_next;
   logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_A_next;
   logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_B_next;
   logic                        data_valid_A;
   logic                        data_valid_B;
   logic                        window_first;
   logic                        window_last;
   logic                        frame_done;
   logic                        busy;

   modport master (
      input  frame_ready, next_stall,
      output frame_ack, ifm_sel,
      output ifm_enable_read_A_next, ifm_enable_read_B_next,
      output ifm_address_read_A_next, ifm_address_read_B_next,
      output data_valid_A, data_valid_B, window_first, window_last,
      output frame_done, busy
   );

   modport slave (
      output frame_ready, next_stall,
      input  frame_ack, ifm_sel,
      input  ifm_enable_read_A_next, ifm_enable_read_B_next,
      input  ifm_address_read_A_next, ifm_address_read_B_next,
      input  data_valid_A, data_valid_B, window_first, window_last,
      input  frame_done, busy
   );
endinterface

// File: rtl/ifm_window_reader.sv
// Claims the freshly written IFM bank and scans it with a KxK stride-1 window,
// issuing two element reads per cycle with flags aligned to the 1-cycle read latency.
module ifm_window_reader #(
   parameter int IFM_SIZE         = 28,
   parameter int KERNEL_SIZE      = 5,
   parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE)
) (
   input  logic                clk,
   input  logic                reset,
   ifm_window_reader_if.master rd
);
   localparam int OFM   = IFM_SIZE - KERNEL_SIZE + 1;
   localparam int K2    = KERNEL_SIZE * KERNEL_SIZE;
   localparam int NPAIR = (K2 + 1) / 2;
   localparam bit ODD   = (K2 % 2) == 1;
   localparam int RW    = $clog2(IFM_SIZE + 2);
   localparam int JW    = $clog2(NPAIR + 1);
   localparam int AW    = ADDRESS_SIZE_IFM;

   typedef enum logic [2:0] {S_IDLE, S_SWAP, S_READ, S_DRAIN, S_DONE} state_t;

   state_t          state_q, state_d;
   logic            sel_q, sel_d;
   logic [RW-1:0]   win_r_q, win_r_d, win_c_q, win_c_d;
   logic [RW-1:0]   a_kr_q, a_kr_d, a_kc_q, a_kc_d;
   logic [RW-1:0]   b_kr_q, b_kr_d, b_kc_q, b_kc_d;
   logic [JW-1:0]   pair_q, pair_d;
   logic            en_a_q, en_a_d, en_b_q, en_b_d;
   logic [AW-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
   logic            val_a_q, val_a_d, val_b_q, val_b_d;
   logic            first_q, first_d, last_q, last_d;
   logic            load;
   logic            last_pair, last_win;

   function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] wr, input logic [RW-1:0] wc,
                                             input logic [RW-1:0] kr, input logic [RW-1:0] kc);
      return AW'((int'(wr) + int'(kr)) * IFM_SIZE + int'(wc) + int'(kc));
   endfunction

   assign last_pair = (pair_q == JW'(NPAIR - 1));
   assign last_win  = (win_r_q == RW'(OFM - 1)) && (win_c_q == RW'(OFM - 1));

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      win_r_d  = win_r_q;
      win_c_d  = win_c_q;
      a_kr_d   = a_kr_q;
      a_kc_d   = a_kc_q;
      b_kr_d   = b_kr_q;
      b_kc_d   = b_kc_q;
      pair_d   = pair_q;
      addr_a_d = addr_a_q;
      addr_b_d = addr_b_q;
      en_a_d   = 1'b0;
      en_b_d   = 1'b0;
      load     = 1'b0;
      // Flags describe the pair currently on the address outputs, one cycle later.
      val_a_d  = en_a_q;
      val_b_d  = en_b_q;
      first_d  = en_a_q && (pair_q == '0);
      last_d   = en_a_q && last_pair;

      case (state_q)
         S_IDLE: begin
            if (rd.frame_ready) begin
               state_d = S_SWAP;
               sel_d   = ~sel_q;
            end
         end
         S_SWAP: begin
            win_r_d = '0;
            win_c_d = '0;
            pair_d  = '0;
            a_kr_d  = '0;
            a_kc_d  = '0;
            b_kr_d  = '0;
            b_kc_d  = RW'(1);
            load    = 1'b1;
            state_d = S_READ;
         end
         S_READ: begin
            // The pair on the outputs has always been issued by now; a stall only delays the next one.
            if (last_pair && last_win) begin
               state_d = S_DRAIN;
            end else if (!rd.next_stall) begin
               load = 1'b1;
               if (last_pair) begin
                  pair_d = '0;
                  a_kr_d = '0;
                  a_kc_d = '0;
                  b_kr_d = '0;
                  b_kc_d = RW'(1);
                  if (win_c_q == RW'(OFM - 1)) begin
                     win_c_d = '0;
                     win_r_d = win_r_q + RW'(1);
                  end else begin
                     win_c_d = win_c_q + RW'(1);
                  end
               end else begin
                  pair_d = pair_q + JW'(1);
                  if (a_kc_q + RW'(2) >= RW'(KERNEL_SIZE)) begin
                     a_kr_d = a_kr_q + RW'(1);
                     a_kc_d = a_kc_q + RW'(2) - RW'(KERNEL_SIZE);
                  end else begin
                     a_kc_d = a_kc_q + RW'(2);
                  end
                  if (b_kc_q + RW'(2) >= RW'(KERNEL_SIZE)) begin
                     b_kr_d = b_kr_q + RW'(1);
                     b_kc_d = b_kc_q + RW'(2) - RW'(KERNEL_SIZE);
                  end else begin
                     b_kc_d = b_kc_q + RW'(2);
                  end
               end
            end
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         en_a_d   = 1'b1;
         en_b_d   = !(ODD && (pair_d == JW'(NPAIR - 1)));
         addr_a_d = addr_of(win_r_d, win_c_d, a_kr_d, a_kc_d);
         addr_b_d = en_b_d ? addr_of(win_r_d, win_c_d, b_kr_d, b_kc_d) : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         sel_q    <= 1'b0;
         win_r_q  <= '0;
         win_c_q  <= '0;
         a_kr_q   <= '0;
         a_kc_q   <= '0;
         b_kr_q   <= '0;
         b_kc_q   <= '0;
         pair_q   <= '0;
         en_a_q   <= 1'b0;
         en_b_q   <= 1'b0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         val_a_q  <= 1'b0;
         val_b_q  <= 1'b0;
         first_q  <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         win_r_q  <= win_r_d;
         win_c_q  <= win_c_d;
         a_kr_q   <= a_kr_d;
         a_kc_q   <= a_kc_d;
         b_kr_q   <= b_kr_d;
         b_kc_q   <= b_kc_d;
         pair_q   <= pair_d;
         en_a_q   <= en_a_d;
         en_b_q   <= en_b_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         val_a_q  <= val_a_d;
         val_b_q  <= val_b_d;
         first_q  <= first_d;
         last_q   <= last_d;
      end
   end

   assign rd.frame_ack               = (state_q == S_SWAP);
   assign rd.frame_done              = (state_q == S_DONE);
   assign rd.busy                    = (state_q != S_IDLE);
   assign rd.ifm_sel                 = sel_q;
   assign rd.ifm_enable_read_A_next  = en_a_q;
   assign rd.ifm_enable_read_B_next  = en_b_q;
   assign rd.ifm_address_read_A_next = addr_a_q;
   assign rd.ifm_address_read_B_next = addr_b_q;
   assign rd.data_valid_A            = val_a_q;
   assign rd.data_valid_B            = val_b_q;
   assign rd.window_first            = first_q;
   assign rd.window_last             = last_q;
endmodule

// File: tb/tb_ifm_window_reader.sv
// Directed bench for ifm_window_reader: a reference scan model feeds a scoreboard of
// expected read pairs and data flags, checked cycle by cycle against the DUT.
module tb_ifm_window_reader;
   localparam int IFM   = 28;
   localparam int K     = 5;
   localparam int OFM   = IFM - K + 1;
   localparam int NPAIR = (K * K + 1) / 2;
   localparam int TOTAL = OFM * OFM * NPAIR;

   typedef struct {
      int a;
      bit enb;
      int b;
      bit first;
      bit last;
   } pair_t;

   typedef struct {
      bit first;
      bit last;
      bit vb;
   } flag_t;

   logic clk = 1'b0;
   logic reset;
   int   n_asserts = 0;
   int   n_fail    = 0;
   pair_t exp_q[$];
   flag_t vq[$];

   int t_idx [7] = '{0, 1, 2, 12, 13, 312, TOTAL - 1};
   int t_a   [7] = '{0, 2, 4, 116, 1, 28, 783};
   int t_enb [7] = '{1, 1, 1, 0, 1, 1, 0};
   int t_b   [7] = '{1, 3, 28, 0, 2, 29, 0};

   always #5 clk = ~clk;

   ifm_window_reader_if #(.ADDRESS_SIZE_IFM(10)) bus1 ();
   ifm_window_reader_if #(.ADDRESS_SIZE_IFM(6))  bus2 ();

   ifm_window_reader #(.IFM_SIZE(IFM), .KERNEL_SIZE(K), .ADDRESS_SIZE_IFM(10)) dut1 (
      .clk   (clk),
      .reset (reset),
      .rd    (bus1)
   );

   ifm_window_reader #(.IFM_SIZE(6), .KERNEL_SIZE(2), .ADDRESS_SIZE_IFM(6)) dut2 (
      .clk   (clk),
      .reset (reset),
      .rd    (bus2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fill_model();
      pair_t p;
      exp_q.delete();
      vq.delete();
      for (int r = 0; r < OFM; r++)
         for (int c = 0; c < OFM; c++)
            for (int j = 0; j < NPAIR; j++) begin
               p.a     = (r + (2*j) / K) * IFM + c + (2*j) % K;
               p.enb   = (2*j + 1) < K * K;
               p.b     = p.enb ? (r + (2*j+1) / K) * IFM + c + (2*j+1) % K : 0;
               p.first = (j == 0);
               p.last  = (j == NPAIR - 1);
               exp_q.push_back(p);
            end
   endtask

   task automatic check_valid(input bit prev_en);
      flag_t f;
      chk("valid_A_lag", bus1.data_valid_A, prev_en);
      if (bus1.data_valid_A) begin
         chk("valid_pending", vq.size() > 0, 1);
         if (vq.size() > 0) begin
            f = vq.pop_front();
            chk("valid_B", bus1.data_valid_B, f.vb);
            chk("window_first", bus1.window_first, f.first);
            chk("window_last", bus1.window_last, f.last);
         end
      end else begin
         chk("valid_B_idle", bus1.data_valid_B, 0);
         chk("first_idle", bus1.window_first, 0);
         chk("last_idle", bus1.window_last, 0);
      end
   endtask

   task automatic run_frame(input int stall_at, input int stall_len, input int abort_at,
                            input logic exp_sel, input bit hold_ready, input bit use_table,
                            output int read_cycles, output int ack_lat);
      pair_t e;
      int    issued = 0, cyc = 0, first_cyc = -1, last_cyc = -1, acks = 0, stall_left = 0;
      bit    got_ack = 0, prev_en = 0, fin = 0;
      read_cycles = -1;
      ack_lat     = -1;
      fill_model();
      for (int i = 1; i <= 20 && !got_ack; i++) begin
         @(negedge clk);
         if (bus1.frame_ack) begin
            got_ack = 1;
            ack_lat = i;
         end
      end
      chk("frame_ack_seen", got_ack, 1);
      chk("ifm_sel_swap", bus1.ifm_sel, exp_sel);
      chk("swap_no_enable", bus1.ifm_enable_read_A_next, 0);
      acks = 1;
      if (!hold_ready) bus1.frame_ready = 1'b0;
      while (!fin && cyc < 9000) begin
         @(negedge clk);
         cyc++;
         if (bus1.frame_ack) acks++;
         check_valid(prev_en);
         prev_en = bus1.ifm_enable_read_A_next;
         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) bus1.next_stall = 1'b0;
         end
         if (bus1.ifm_enable_read_A_next) begin
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            chk("issue_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("addr_A", bus1.ifm_address_read_A_next, e.a);
               chk("en_B", bus1.ifm_enable_read_B_next, e.enb);
               chk("addr_B", bus1.ifm_address_read_B_next, e.b);
               vq.push_back('{e.first, e.last, e.enb});
            end
            if (use_table)
               for (int t = 0; t < 7; t++)
                  if (issued == t_idx[t]) begin
                     chk("tbl_addr_A", bus1.ifm_address_read_A_next, t_a[t]);
                     chk("tbl_en_B", bus1.ifm_enable_read_B_next, t_enb[t]);
                     chk("tbl_addr_B", bus1.ifm_address_read_B_next, t_b[t]);
                  end
            if (issued == stall_at) begin
               bus1.next_stall = 1'b1;
               stall_left      = stall_len;
            end
            issued++;
            if (issued == abort_at || issued == TOTAL) fin = 1;
         end else begin
            chk("en_B_without_A", bus1.ifm_enable_read_B_next, 0);
         end
      end
      chk("frame_progress", fin, 1);
      chk("first_enable_latency", first_cyc, 1);
      if (abort_at < 0 && fin) begin
         read_cycles = last_cyc - first_cyc + 1;
         @(negedge clk);
         if (bus1.frame_ack) acks++;
         check_valid(prev_en);
         chk("drain_en_A", bus1.ifm_enable_read_A_next, 0);
         chk("drain_done", bus1.frame_done, 0);
         chk("drain_busy", bus1.busy, 1);
         prev_en = bus1.ifm_enable_read_A_next;
         @(negedge clk);
         if (bus1.frame_ack) acks++;
         check_valid(prev_en);
         chk("done_pulse", bus1.frame_done, 1);
         chk("done_busy", bus1.busy, 1);
         @(negedge clk);
         chk("done_single", bus1.frame_done, 0);
         chk("idle_busy", bus1.busy, 0);
         chk("one_ack_per_frame", acks, 1);
         chk("sel_stable", bus1.ifm_sel, exp_sel);
         chk("flags_drained", vq.size(), 0);
      end
   endtask

   initial begin
      int rc, lat, got, cnt, f2, l2, done2, a_first, b_first, a_last, b_last;
      reset            = 1'b1;
      bus1.frame_ready = 1'b0;
      bus1.next_stall  = 1'b0;
      bus2.frame_ready = 1'b0;
      bus2.next_stall  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sel", bus1.ifm_sel, 0);
      chk("rst_busy", bus1.busy, 0);
      chk("rst_en_A", bus1.ifm_enable_read_A_next, 0);
      chk("rst_en_B", bus1.ifm_enable_read_B_next, 0);
      chk("rst_valid_A", bus1.data_valid_A, 0);
      chk("rst_ack", bus1.frame_ack, 0);
      reset = 1'b0;

      // Frame 1: plain frame, verify swap latency and full-frame length.
      @(negedge clk);
      bus1.frame_ready = 1'b1;
      run_frame(-1, 0, -1, 1'b1, 1'b0, 1'b1, rc, lat);
      $display("frame1: ack latency %0d, read cycles %0d", lat, rc);
      chk("f1_ack_latency", lat, 1);
      chk("f1_read_cycles", rc, TOTAL);

      // Frame 2: frame_ready held high throughout, 3-cycle stall after pair (2,3).
      @(negedge clk);
      bus1.frame_ready = 1'b1;
      run_frame(1, 3, -1, 1'b0, 1'b1, 1'b0, rc, lat);
      $display("frame2: ack latency %0d, read cycles %0d", lat, rc);
      chk("f2_read_cycles", rc, TOTAL + 3);

      // Frame 3 starts on the still-high frame_ready, then is aborted by reset.
      run_frame(-1, 0, 50, 1'b1, 1'b1, 1'b0, rc, lat);
      $display("frame3: ack latency %0d, aborted after 50 issues", lat);
      chk("f3_ack_latency", lat, 1);
      reset            = 1'b1;
      bus1.frame_ready = 1'b0;
      @(negedge clk);
      chk("abort_sel", bus1.ifm_sel, 0);
      chk("abort_busy", bus1.busy, 0);
      chk("abort_en_A", bus1.ifm_enable_read_A_next, 0);
      chk("abort_en_B", bus1.ifm_enable_read_B_next, 0);
      chk("abort_addr_A", bus1.ifm_address_read_A_next, 0);
      chk("abort_addr_B", bus1.ifm_address_read_B_next, 0);
      chk("abort_valid_A", bus1.data_valid_A, 0);
      chk("abort_valid_B", bus1.data_valid_B, 0);
      chk("abort_first", bus1.window_first, 0);
      chk("abort_last", bus1.window_last, 0);
      chk("abort_done", bus1.frame_done, 0);
      reset = 1'b0;

      // Frame 4: restart after reset begins at (0,1) with ifm_sel 0->1.
      @(negedge clk);
      bus1.frame_ready = 1'b1;
      run_frame(-1, 0, -1, 1'b1, 1'b0, 1'b1, rc, lat);
      $display("frame4: ack latency %0d, read cycles %0d", lat, rc);
      chk("f4_read_cycles", rc, TOTAL);

      // Small even-K2 instance: 6x6 IFM, 2x2 kernel.
      @(negedge clk);
      bus2.frame_ready = 1'b1;
      got = 0;
      for (int i = 0; i < 20 && got == 0; i++) begin
         @(negedge clk);
         if (bus2.frame_ack) got = 1;
      end
      bus2.frame_ready = 1'b0;
      chk("k2_ack", got, 1);
      chk("k2_sel", bus2.ifm_sel, 1);
      cnt = 0; f2 = -1; l2 = -1; done2 = -1;
      a_first = -1; b_first = -1; a_last = -1; b_last = -1;
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk);
         if (bus2.ifm_enable_read_A_next) begin
            cnt++;
            chk("k2_en_B", bus2.ifm_enable_read_B_next, 1);
            if (f2 < 0) begin
               f2      = i;
               a_first = int'(bus2.ifm_address_read_A_next);
               b_first = int'(bus2.ifm_address_read_B_next);
            end
            l2     = i;
            a_last = int'(bus2.ifm_address_read_A_next);
            b_last = int'(bus2.ifm_address_read_B_next);
         end
         if (bus2.frame_done && done2 < 0) done2 = i;
      end
      $display("k2 frame: %0d issues, read cycles %0d, last pair (%0d,%0d)", cnt, l2 - f2 + 1, a_last, b_last);
      chk("k2_issues", cnt, 50);
      chk("k2_read_cycles", l2 - f2 + 1, 50);
      chk("k2_first_A", a_first, 0);
      chk("k2_first_B", b_first, 1);
      chk("k2_last_A", a_last, 34);
      chk("k2_last_B", b_last, 35);
      chk("k2_done_offset", done2 - l2, 2);
      chk("k2_idle", bus2.busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule

// File: doc/ifm_window_reader.md
# ifm_window_reader

Next-layer-side read sequencer for a two-bank ping-pong IFM memory array. The writer fills one bank while this block reads the other. For each frame it claims the freshly written bank by toggling `ifm_sel`, then scans it with a KERNEL_SIZE×KERNEL_SIZE window (stride 1, no padding) and issues two reads per cycle on ports A and B. It emits per-read valid/first/last flags aligned to the array's 1-cycle read data latency, and signals frame completion.

## Interface
- IFM_SIZE, 28, IFM side length in pixels
- KERNEL_SIZE, 5, window side length
- ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), address width
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high reset
- frame_ready  in  1  level; writer has completed a full bank
- next_stall  in  1  consumer backpressure; freezes issue
- frame_ack  out  1  1-cycle pulse when the bank is claimed (`ifm_sel` toggles)
- ifm_sel  out  1  bank select to the memory array
- ifm_enable_read_A_next  out  1  port A read enable
- ifm_enable_read_B_next  out  1  port B read enable
- ifm_address_read_A_next  out  ADDRESS_SIZE_IFM  port A address
- ifm_address_read_B_next  out  ADDRESS_SIZE_IFM  port B address
- data_valid_A  out  1  port A data valid this cycle (enable delayed 1)
- data_valid_B  out  1  port B data valid this cycle
- window_first  out  1  valid data is the first read of a window
- window_last  out  1  valid data is the last read of a window
- frame_done  out  1  1-cycle pulse after the last data of the frame
- busy  out  1  high in every state except IDLE

## Operation
- OFM = IFM_SIZE−KERNEL_SIZE+1. Windows are scanned row-major by (r,c) over 0..OFM−1. Window elements e = 0..K²−1 map to kr = e/K and kc = e%K.
- Address of element e in window (r,c): (r+kr)*IFM_SIZE + (c+kc).
- Each issue cycle reads element pair (2j, 2j+1): A takes 2j, B takes 2j+1. A window takes ceil(K²/2) issue cycles. When K² is odd, B enable is low in the last cycle and B address is 0.
- Counters hold incremental (kr,kc) for A and B. The RTL contains no dividers; the only multiply is by the constant IFM_SIZE.
- States:
  - IDLE: leave when frame_ready=1 → SWAP.
  - SWAP (1 cycle): toggle `ifm_sel`, pulse frame_ack, clear counters → READ.
  - READ: issue reads while next_stall=0. After the last pair of window (OFM−1, OFM−1) → DRAIN.
  - DRAIN (1 cycle): last data returns → DONE.
  - DONE (1 cycle): pulse frame_done → IDLE.
- Stall: while next_stall=1 in READ, both enables are 0, all counters and addresses hold, and nothing is skipped or repeated. next_stall is ignored outside READ.
- frame_ready is sampled only in IDLE. Asserting it while busy has no effect until IDLE. If it is still high in IDLE, the next frame starts, toggling `ifm_sel` back.
- window_first and window_last are registered along with the valid flags. window_last accompanies the pair carrying element K²−1.
- Reset (including mid-frame): state IDLE, ifm_sel=0, all enables, addresses and flags 0, counters 0. In-flight data is discarded.

## Timing
- frame_ready high in IDLE at edge N → SWAP during cycle N+1 (frame_ack=1, `ifm_sel` new value) → first enables in cycle N+2 → data_valid_A/B in cycle N+3.
- Valid flags equal the enables delayed by exactly 1 cycle. Addresses and enables are registered outputs.
- With no stalls, READ lasts OFM²·ceil(K²/2) cycles: 24·24·13 = 7488 for the defaults.
- frame_done occurs exactly 2 cycles after the last issue cycle (DRAIN, then DONE). busy returns to 0 the cycle after frame_done.
- A stall of S cycles lengthens READ by exactly S.

## Test plan
- Reset, then frame_ready=1 with defaults → SWAP: ifm_sel 0→1 and frame_ack for 1 cycle. Issue cycles 0..2 for window (0,0): (A,B) = (0,1), (2,3), (4,28). Cycle 12: A=116 with B enable 0. window_first on the first valid, window_last on the 13th.
- Window (0,1) first pair = (1,2). Window (1,0) first pair = (28,29). Last frame pair: A=783, B disabled. frame_done exactly 2 cycles later. Total READ = 7488 cycles.
- Assert next_stall for 3 cycles mid-window (0,0) after pair (2,3) → enables 0 for 3 cycles, next pair is (4,28), valid gap of 3 cycles, READ = 7491 cycles.
- Keep frame_ready high continuously → second frame toggles ifm_sel 1→0. Exactly one frame_ack per frame. Assertion during READ is not acted upon early.
- Assert reset in the middle of READ → next cycle: IDLE, ifm_sel=0, all outputs 0. A new frame_ready restarts from (0,1).
- Parameters IFM_SIZE=6, KERNEL_SIZE=2 (even K²) → B enabled every cycle, 2 cycles per window. Window (4,4) last pair = (34,35). READ = 50 cycles.
